// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock.
// Optional build macro AUTO_CONV_EN: self-start on bin_in change instead of using start.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 20,
   parameter int DIGITS = 6
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic                  start,
   output logic                  ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  done,
   output logic                  ovf
);

   localparam int ACC_W = 4*DIGITS + 4;
   localparam int CNT_W = $clog2(BIN_W) + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   function automatic logic [63:0] max_bcd_val(input int d);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < d; i++) v = v * 64'd10;
      return v - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL  = max_bcd_val(DIGITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   logic [1:0]            r_state;
   logic [BIN_W-1:0]      r_shift;
   logic [BIN_W-1:0]      r_bin_lat;
   logic [ACC_W-1:0]      r_accum;
   logic [CNT_W-1:0]      r_cnt;
   logic [4*DIGITS-1:0]   r_bcd;
   logic                  r_done;
   logic                  r_ovf;

   logic [ACC_W-1:0]      w_adj;
   logic [ACC_W-1:0]      w_acc_next;
   logic                  w_go;
   logic                  w_ovf;

   // Add-3 correction on every nibble, guard nibble included.
   generate
      for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
         assign w_adj[4*gi +: 4] = (r_accum[4*gi +: 4] >= 4'd5) ?
                                   (r_accum[4*gi +: 4] + 4'd3) : r_accum[4*gi +: 4];
      end
   endgenerate

   assign w_acc_next = (w_adj << 1) | ACC_W'(r_shift[BIN_W-1]);
   assign w_ovf      = (64'(r_bin_lat) > MAX_VAL);

`ifdef AUTO_CONV_EN
   logic r_init_done;

   // First conversion after reset happens even if bin_in equals the cleared copy.
   assign w_go = !r_init_done || (bin_in != r_bin_lat);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_init_done <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_init_done <= 1'b1;
      end
   end
`else
   assign w_go = start;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bin_lat <= '0;
         r_accum   <= '0;
         r_cnt     <= '0;
         r_bcd     <= '0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_shift   <= bin_in;
                  r_bin_lat <= bin_in;
                  r_accum   <= '0;
                  r_cnt     <= '0;
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_accum <= w_acc_next;
               r_shift <= r_shift << 1;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (w_ovf) begin
                  r_bcd <= {DIGITS{4'h9}};
                  r_ovf <= 1'b1;
               end else begin
                  r_bcd <= r_accum[4*DIGITS-1:0];
                  r_ovf <= 1'b0;
               end
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready   = (r_state == ST_IDLE);
   assign bcd_out = r_bcd;
   assign done    = r_done;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default 20-bit / 6-digit build).
// Define AUTO_CONV_EN for both files to exercise the self-start build instead.
module tb_bin_to_bcd_seq;

   logic          sys_clk;
   logic          sys_rst_n;
   logic [19:0]   bin_in;
   logic          start;
   logic          ready;
   logic [23:0]   bcd_out;
   logic          done;
   logic          ovf;

   int n_checks = 0;
   int n_errors = 0;

   bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bin_in    (bin_in),
      .start     (start),
      .ready     (ready),
      .bcd_out   (bcd_out),
      .done      (done),
      .ovf       (ovf)
   );

   initial sys_clk = 1'b0;
   always #10 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Returns the number of rising edges until done is seen; limit+1 on timeout.
   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         n++;
         if (done) return;
      end
      n = limit + 1;
   endtask

   task automatic count_dones(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         if (done) cnt++;
      end
   endtask

`ifndef AUTO_CONV_EN
   // One full start-to-done transaction, launched from a negedge while idle.
   task automatic convert(input logic [19:0] v, input logic [23:0] exp_bcd, input logic exp_ovf);
      int n;
      @(negedge sys_clk);
      bin_in = v;
      start  = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      start = 1'b0;
      check_val("busy_ready", 64'(ready), 64'd0);
      wait_done(40, n);
      check_val("latency", 64'(n), 64'd21);
      check_val("bcd", 64'(bcd_out), 64'(exp_bcd));
      check_val("ovf", 64'(ovf), 64'(exp_ovf));
      check_val("ready_at_done", 64'(ready), 64'd1);
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_val("done_pulse", 64'(done), 64'd0);
      check_val("bcd_hold", 64'(bcd_out), 64'(exp_bcd));
      $display("conv bin=%0d bcd=%06h ovf=%0d latency=%0d", v, bcd_out, ovf, n);
   endtask
`endif

   initial begin
      int n;
      int cnt;
      sys_rst_n = 1'b0;
      bin_in    = 20'd0;
      start     = 1'b0;
`ifdef AUTO_CONV_EN
      bin_in = 20'd7;
`endif
      repeat (3) @(negedge sys_clk);
      check_val("rst_ready", 64'(ready), 64'd1);
      check_val("rst_bcd", 64'(bcd_out), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_ovf", 64'(ovf), 64'd0);
      sys_rst_n = 1'b1;

`ifdef AUTO_CONV_EN
      // Self-start once after reset, then again on a bin_in change.
      wait_done(40, n);
      check_val("auto_lat0", 64'(n), 64'd22);
      check_val("auto_bcd7", 64'(bcd_out), 64'h000007);
      $display("auto bin=7 bcd=%06h latency=%0d", bcd_out, n);
      bin_in = 20'd8;
      wait_done(40, n);
      check_val("auto_lat1", 64'(n), 64'd22);
      check_val("auto_bcd8", 64'(bcd_out), 64'h000008);
      check_val("auto_ovf", 64'(ovf), 64'd0);
      $display("auto bin=8 bcd=%06h latency=%0d", bcd_out, n);
      count_dones(30, cnt);
      check_val("auto_idle", 64'(cnt), 64'd0);
`else
      convert(20'd0,       24'h000000, 1'b0);
      convert(20'd255,     24'h000255, 1'b0);
      convert(20'd123456,  24'h123456, 1'b0);
      convert(20'd999999,  24'h999999, 1'b0);
      convert(20'd1000000, 24'h999999, 1'b1);
      convert(20'd1048575, 24'h999999, 1'b1);
      convert(20'd42,      24'h000042, 1'b0);

      // Second start and bin_in change mid-run must be ignored.
      @(negedge sys_clk);
      bin_in = 20'd12;
      start  = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      start = 1'b0;
      repeat (4) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
      end
      bin_in = 20'd34;
      start  = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      start = 1'b0;
      wait_done(40, n);
      check_val("ign_lat", 64'(n), 64'd16);
      check_val("ign_bcd", 64'(bcd_out), 64'h000012);
      $display("ignore bin=12/34 bcd=%06h", bcd_out);
      count_dones(30, cnt);
      check_val("ign_no_queue", 64'(cnt), 64'd0);

      // Start held high: back-to-back conversions, each re-sampling bin_in.
      @(negedge sys_clk);
      bin_in = 20'd1;
      start  = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      wait_done(40, n);
      check_val("lvl_lat1", 64'(n), 64'd21);
      check_val("lvl_bcd1", 64'(bcd_out), 64'h000001);
      $display("level bin=1 bcd=%06h gap=%0d", bcd_out, n);
      bin_in = 20'd2;
      wait_done(40, n);
      check_val("lvl_gap2", 64'(n), 64'd22);
      check_val("lvl_bcd2", 64'(bcd_out), 64'h000002);
      $display("level bin=2 bcd=%06h gap=%0d", bcd_out, n);
      bin_in = 20'd3;
      wait_done(40, n);
      check_val("lvl_gap3", 64'(n), 64'd22);
      check_val("lvl_bcd3", 64'(bcd_out), 64'h000003);
      $display("level bin=3 bcd=%06h gap=%0d", bcd_out, n);
      start = 1'b0;
      count_dones(25, cnt);
      check_val("lvl_stop", 64'(cnt), 64'd0);

      // Asynchronous reset in the middle of a conversion.
      @(negedge sys_clk);
      bin_in = 20'd555;
      start  = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      start = 1'b0;
      repeat (9) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
      end
      #2 sys_rst_n = 1'b0;
      #1;
      check_val("arst_bcd", 64'(bcd_out), 64'd0);
      check_val("arst_ready", 64'(ready), 64'd1);
      check_val("arst_done", 64'(done), 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      count_dones(30, cnt);
      check_val("arst_no_done", 64'(cnt), 64'd0);
      check_val("arst_idle", 64'(ready), 64'd1);
      check_val("arst_bcd_hold", 64'(bcd_out), 64'd0);
      $display("async reset mid-run bcd=%06h ready=%0d", bcd_out, ready);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
